// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: paddle move, ball move, collision/scoring, commit.
// Optional build macro PONG_AUTO_P2_EN makes the right paddle CPU-driven.
module pong_game_ctrl #(
  parameter int unsigned P1_X      = 20,
  parameter int unsigned P2_X      = 610,
  parameter int unsigned PAD_SPD   = 4,
  parameter int unsigned BALL_SPD  = 3,
  parameter int unsigned SERVE_DLY = 60,
  parameter int unsigned WIN_SCORE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_pulse,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       serve,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [9:0] x2,
  output logic [9:0] y2,
  output logic [9:0] xb,
  output logic [9:0] yb,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned SERVE_W = $clog2(SERVE_DLY + 1);

  typedef logic signed [10:0] s11_t;

  localparam s11_t P1X    = 11'(P1_X);
  localparam s11_t P2X    = 11'(P2_X);
  localparam s11_t PAD_S  = 11'(PAD_SPD);
  localparam s11_t BALL_S = 11'(BALL_SPD);
  localparam s11_t Y_MIN  = 11'sd7;
  localparam s11_t Y_MAX  = 11'sd392;
  localparam s11_t Y_TOP  = 11'sd11;
  localparam s11_t Y_BOT  = 11'sd468;
  localparam s11_t X_MID  = 11'sd320;
  localparam s11_t Y_MID  = 11'sd240;

  typedef enum logic [2:0] {
    S_IDLE, S_PADDLE, S_BALL, S_COLLIDE, S_COMMIT, S_OVER
  } state_t;

  state_t state, next_state;

  logic               dir_x, dir_y;
  logic [SERVE_W-1:0] serve_cnt, w_serve, c_serve;
  logic [9:0]         py1, py2, c_x, c_y;
  s11_t               nx, ny;
  logic               c_dx, c_dy, c_win;
  logic [3:0]         c_s1, c_s2;

  s11_t               cx_c, cy_c;
  logic               cdx_c, cdy_c;
  logic [3:0]         cs1_c, cs2_c;
  logic [SERVE_W-1:0] cserve_c;

  function automatic s11_t to_s(input logic [9:0] v);
    return s11_t'({1'b0, v});
  endfunction

  function automatic s11_t clamp(input s11_t y);
    if (y < Y_MIN) return Y_MIN;
    if (y > Y_MAX) return Y_MAX;
    return y;
  endfunction

  function automatic s11_t pad_move(input s11_t y, input logic up, input logic dn);
    if (up && !dn) return clamp(y - PAD_S);
    if (dn && !up) return clamp(y + PAD_S);
    return y;
  endfunction

  function automatic logic [3:0] inc_sat(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

`ifdef PONG_AUTO_P2_EN
  // CPU paddle chases the committed ball row with a +/-2 dead band.
  function automatic s11_t pad_auto(input s11_t y, input s11_t b);
    if (b < y + 11'sd38) return clamp(y - PAD_S);
    if (b > y + 11'sd42) return clamp(y + PAD_S);
    return y;
  endfunction
`endif

  assign x1 = 10'(P1_X);
  assign x2 = 10'(P2_X);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (frame_pulse) next_state = S_PADDLE;
      S_PADDLE:  next_state = S_BALL;
      S_BALL:    next_state = S_COLLIDE;
      S_COLLIDE: next_state = S_COMMIT;
      S_COMMIT:  next_state = c_win ? S_OVER : S_IDLE;
      S_OVER:    if (serve) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Collision resolution; paddle window uses this frame's updated paddle rows.
  always_comb begin
    cx_c     = nx;
    cy_c     = ny;
    cdx_c    = dir_x;
    cdy_c    = dir_y;
    cs1_c    = score1;
    cs2_c    = score2;
    cserve_c = w_serve;
    if (ny < Y_TOP) begin
      cy_c  = Y_TOP;
      cdy_c = 1'b1;
    end else if (ny > Y_BOT) begin
      cy_c  = Y_BOT;
      cdy_c = 1'b0;
    end
    if (!dir_x && (nx - 11'sd4 <= P1X + 11'sd9) && (to_s(xb) - 11'sd4 > P1X + 11'sd9) &&
        (cy_c >= to_s(py1) - 11'sd3) && (cy_c <= to_s(py1) + 11'sd83)) begin
      cx_c  = P1X + 11'sd14;
      cdx_c = 1'b1;
    end else if (dir_x && (nx + 11'sd4 >= P2X) && (to_s(xb) + 11'sd4 < P2X) &&
                 (cy_c >= to_s(py2) - 11'sd3) && (cy_c <= to_s(py2) + 11'sd83)) begin
      cx_c  = P2X - 11'sd5;
      cdx_c = 1'b0;
    end else if (nx < 11'sd4) begin
      cs2_c    = inc_sat(score2);
      cx_c     = X_MID;
      cy_c     = Y_MID;
      cserve_c = SERVE_W'(SERVE_DLY);
      cdx_c    = 1'b0;
    end else if (nx > 11'sd635) begin
      cs1_c    = inc_sat(score1);
      cx_c     = X_MID;
      cy_c     = Y_MID;
      cserve_c = SERVE_W'(SERVE_DLY);
      cdx_c    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1 <= 10'd200;  y2 <= 10'd200;
      xb <= 10'd320;  yb <= 10'd240;
      score1 <= '0;   score2 <= '0;
      dir_x <= 1'b1;  dir_y <= 1'b1;
      serve_cnt <= SERVE_W'(SERVE_DLY);
      w_serve <= '0;  c_serve <= '0;
      py1 <= '0;      py2 <= '0;
      nx <= '0;       ny <= '0;
      c_x <= '0;      c_y <= '0;
      c_dx <= 1'b0;   c_dy <= 1'b0;
      c_s1 <= '0;     c_s2 <= '0;
      c_win <= 1'b0;
      game_over <= 1'b0;
      busy <= 1'b0;
    end else begin
      game_over <= (next_state == S_OVER);
      busy      <= (next_state != S_IDLE) && (next_state != S_OVER);
      case (state)
        S_PADDLE: begin
          py1 <= 10'(pad_move(to_s(y1), p1_up, p1_dn));
`ifdef PONG_AUTO_P2_EN
          py2 <= 10'(pad_auto(to_s(y2), to_s(yb)));
`else
          py2 <= 10'(pad_move(to_s(y2), p2_up, p2_dn));
`endif
        end
        S_BALL: begin
          if (serve_cnt != '0) begin
            w_serve <= serve_cnt - SERVE_W'(1);
            nx <= X_MID;
            ny <= Y_MID;
          end else begin
            w_serve <= '0;
            nx <= dir_x ? to_s(xb) + BALL_S : to_s(xb) - BALL_S;
            ny <= dir_y ? to_s(yb) + BALL_S : to_s(yb) - BALL_S;
          end
        end
        S_COLLIDE: begin
          c_x     <= 10'(cx_c);
          c_y     <= 10'(cy_c);
          c_dx    <= cdx_c;
          c_dy    <= cdy_c;
          c_s1    <= cs1_c;
          c_s2    <= cs2_c;
          c_serve <= cserve_c;
          c_win   <= (cs1_c >= 4'(WIN_SCORE)) || (cs2_c >= 4'(WIN_SCORE));
        end
        S_COMMIT: begin
          y1 <= py1;   y2 <= py2;
          xb <= c_x;   yb <= c_y;
          dir_x <= c_dx;
          dir_y <= c_dy;
          score1 <= c_s1;
          score2 <= c_s2;
          serve_cnt <= c_serve;
        end
        S_OVER: begin
          if (serve) begin
            score1 <= '0;   score2 <= '0;
            y1 <= 10'd200;  y2 <= 10'd200;
            xb <= 10'd320;  yb <= 10'd240;
            serve_cnt <= SERVE_W'(SERVE_DLY);
            dir_x <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level integer game model pushes
// expected outputs per frame_pulse; they are popped when busy falls.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_pulse = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] x1, y1, x2, y2, xb, yb;
  logic [3:0] score1, score2;
  logic       game_over, busy;

  int checks = 0;
  int errors = 0;

  // model state
  int m_y1, m_y2, m_xb, m_yb, m_dx, m_dy, m_serve, m_s1, m_s2;
  bit m_over;

  logic [48:0] exp_q[$];

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .serve(serve),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
    .score1(score1), .score2(score2), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] dut_outs();
    return {y1, y2, xb, yb, score1, score2, game_over};
  endfunction

  function automatic logic [48:0] model_outs();
    return {10'(m_y1), 10'(m_y2), 10'(m_xb), 10'(m_yb), 4'(m_s1), 4'(m_s2), m_over};
  endfunction

  task automatic model_reset();
    m_y1 = 200; m_y2 = 200; m_xb = 320; m_yb = 240;
    m_dx = 1; m_dy = 1; m_serve = 60; m_s1 = 0; m_s2 = 0; m_over = 0;
  endtask

  function automatic int pad(input int y, input bit up, input bit dn);
    int t = y;
    if (up && !dn) t = y - 4;
    else if (dn && !up) t = y + 4;
    if (t < 7) t = 7;
    if (t > 392) t = 392;
    return t;
  endfunction

  task automatic model_step(input bit u1, input bit d1, input bit u2, input bit d2);
    int ny1, ny2, nx, ny;
    ny1 = pad(m_y1, u1, d1);
`ifdef PONG_AUTO_P2_EN
    ny2 = pad(m_y2, m_yb < m_y2 + 38, m_yb > m_y2 + 42);
`else
    ny2 = pad(m_y2, u2, d2);
`endif
    if (m_serve > 0) begin
      m_serve--; nx = 320; ny = 240;
    end else begin
      nx = m_xb + 3 * m_dx; ny = m_yb + 3 * m_dy;
    end
    if (ny < 11) begin ny = 11; m_dy = 1; end
    else if (ny > 468) begin ny = 468; m_dy = -1; end
    if (m_dx < 0 && nx - 4 <= 29 && m_xb - 4 > 29 && ny >= ny1 - 3 && ny <= ny1 + 83) begin
      nx = 34; m_dx = 1;
    end else if (m_dx > 0 && nx + 4 >= 610 && m_xb + 4 < 610 && ny >= ny2 - 3 && ny <= ny2 + 83) begin
      nx = 605; m_dx = -1;
    end else if (nx < 4) begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; nx = 320; ny = 240; m_serve = 60; m_dx = -1;
    end else if (nx > 635) begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; nx = 320; ny = 240; m_serve = 60; m_dx = 1;
    end
    m_y1 = ny1; m_y2 = ny2; m_xb = nx; m_yb = ny;
    m_over = (m_s1 >= 9) || (m_s2 >= 9);
  endtask

  // wait for busy to drop, check the 4-clock latency, then compare against the queue
  task automatic wait_commit(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    if (exp_q.size() > 0) check(tag, 64'(dut_outs()), 64'(exp_q.pop_front()));
    else check({tag, "_queue_empty"}, 64'd1, 64'd0);
  endtask

  task automatic run_frame(input bit u1, input bit d1, input bit u2, input bit d2, input string tag);
    bit was_over;
    @(negedge clk);
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    frame_pulse = 1'b1;
    was_over = m_over;
    if (!was_over) model_step(u1, d1, u2, d2);
    exp_q.push_back(model_outs());
    @(negedge clk);
    frame_pulse = 1'b0;
    if (was_over) begin
      repeat (6) @(negedge clk);
      check({tag, "_over_busy"}, 64'(busy), 64'd0);
      check({tag, "_over_frozen"}, 64'(dut_outs()), 64'(exp_q.pop_front()));
    end else begin
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      wait_commit(tag);
    end
  endtask

  initial begin
    bit u;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outs", 64'(dut_outs()), 64'(model_outs()));
    check("rst_x1", 64'(x1), 64'd20);
    check("rst_x2", 64'(x2), 64'd610);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // T1: first frame holds ball at centre
    run_frame(0, 0, 0, 0, "t1");
    check("t1_y1", 64'(y1), 64'd200);
    check("t1_ball", 64'({xb, yb}), 64'({10'd320, 10'd240}));

    // T2: paddle to top clamp and hold
    for (int i = 0; i < 49; i++) run_frame(1, 0, 0, 1, "t2_up");
    check("t2_y1_49", 64'(y1), 64'd7);
    check("t2_y2_49", 64'(y2), 64'd392);
    for (int i = 0; i < 11; i++) run_frame(1, 0, 0, 0, "t2_hold");
    check("t2_y1_60", 64'(y1), 64'd7);
    for (int i = 0; i < 5; i++) run_frame(1, 1, 1, 1, "t2_both");
    check("t2_both_y1", 64'(y1), 64'd7);

    // T6a: second frame_pulse during BALL is ignored
    @(negedge clk);
    frame_pulse = 1'b1;
    model_step(0, 0, 0, 0);
    exp_q.push_back(model_outs());
    @(negedge clk); frame_pulse = 1'b0;
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
    begin
      int n = 0;
      while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      check("t6_one_update_time", 64'(n), 64'd2);
      check("t6_one_update", 64'(dut_outs()), 64'(exp_q.pop_front()));
    end
    repeat (8) @(negedge clk);
    check("t6_no_second_busy", 64'(busy), 64'd0);
    check("t6_no_second", 64'(dut_outs()), 64'(model_outs()));

    // T6b: async reset while in COLLIDE
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_rst_outs", 64'(dut_outs()), 64'(model_outs()));
    check("t6_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // T3/T4/T5: play a full game, paddles steering away from the ball
    for (int f = 0; f < 4000 && !m_over; f++) begin
      u = (m_yb >= 240);
      run_frame(u, !u, (f % 7) < 3, (f % 7) >= 3, "play");
    end
    check("game_over_reached", 64'(game_over), 64'd1);
    check("win_score", 64'((score1 == 4'd9) || (score2 == 4'd9)), 64'd1);
    check("over_busy", 64'(busy), 64'd0);

    run_frame(0, 0, 0, 0, "over_ignore");

    // serve restarts from OVER
    @(negedge clk);
    serve = 1'b1;
    m_s1 = 0; m_s2 = 0; m_y1 = 200; m_y2 = 200; m_xb = 320; m_yb = 240;
    m_serve = 60; m_dx = 1; m_over = 0;
    @(negedge clk);
    serve = 1'b0;
    check("serve_restart", 64'(dut_outs()), 64'(model_outs()));
    check("serve_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) run_frame(0, 1, 1, 0, "post_serve");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
